mac_operand_sequencer: RTL and testbench

- Initiator for one mac_unit. Accepts a dot-product command: operand base addresses, B stride and term count.
- Fetches signed 8-bit operand pairs from two synchronous-read operand memories. Drives the MAC's a/b/enable/start inputs, one term per cycle.
- Captures the final 32-bit accumulator and returns it on a valid/ready result port.
- Sits between the matrix control FSM and the MAC array; one instance per MAC.

---
 rtl/mac_operand_sequencer_if.sv | 52 +++++
 rtl/mac_operand_sequencer.sv | 108 ++++++++++
 tb/tb_mac_operand_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_operand_sequencer_if.sv
// rtl/mac_operand_sequencer_if.sv - command, operand-read, MAC-drive and result bundle for one sequencer
interface mac_operand_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_a_base;
    logic [ADDR_W-1:0] cmd_b_base;
    logic [ADDR_W-1:0] cmd_b_stride;
    logic [LEN_W-1:0]  cmd_len;

    logic              a_rd_en;
    logic [ADDR_W-1:0] a_rd_addr;
    logic [7:0]        a_rd_data;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_rd_addr;
    logic [7:0]        b_rd_data;

    logic [7:0]        mac_a;
    logic [7:0]        mac_b;
    logic              mac_enable;
    logic              mac_start;
    logic [31:0]       mac_acc;

    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_data;

    // master is the sequencer itself; slave is the surrounding control, memories and MAC
    modport master (
        input  cmd_valid, cmd_a_base, cmd_b_base, cmd_b_stride, cmd_len,
        output cmd_ready,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        input  a_rd_data, b_rd_data,
        output mac_a, mac_b, mac_enable, mac_start,
        input  mac_acc,
        output res_valid, res_data,
        input  res_ready
    );

    modport slave (
        output cmd_valid, cmd_a_base, cmd_b_base, cmd_b_stride, cmd_len,
        input  cmd_ready,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
        output a_rd_data, b_rd_data,
        input  mac_a, mac_b, mac_enable, mac_start,
        output mac_acc,
        input  res_valid, res_data,
        output res_ready
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// rtl/mac_operand_sequencer.sv - fetches operand pairs, drives one MAC per term and returns the dot product
module mac_operand_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mac_operand_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CAPTURE, RESULT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] b_stride;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              rd_en;
    logic              first;
    logic              cmd_ready_q;
    logic              mac_enable_q;
    logic              mac_start_q;
    logic              res_valid_q;
    logic [31:0]       res_data_q;

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.a_rd_en    = rd_en;
    assign bus.b_rd_en    = rd_en;
    assign bus.a_rd_addr  = a_addr;
    assign bus.b_rd_addr  = b_addr;
    assign bus.mac_enable = mac_enable_q;
    assign bus.mac_start  = mac_start_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;

    // Memory data arrives one cycle after the strobe, exactly when mac_enable is high
    assign bus.mac_a = mac_enable_q ? bus.a_rd_data : 8'd0;
    assign bus.mac_b = mac_enable_q ? bus.b_rd_data : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            b_stride     <= '0;
            len          <= '0;
            issued       <= '0;
            a_addr       <= '0;
            b_addr       <= '0;
            rd_en        <= 1'b0;
            first        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            mac_enable_q <= 1'b0;
            mac_start_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
        end else begin
            mac_enable_q <= rd_en;
            mac_start_q  <= rd_en & first;
            first        <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        b_stride    <= bus.cmd_b_stride;
                        len         <= bus.cmd_len;
                        if (bus.cmd_len != '0) begin
                            state  <= ISSUE;
                            rd_en  <= 1'b1;
                            first  <= 1'b1;
                            a_addr <= bus.cmd_a_base;
                            b_addr <= bus.cmd_b_base;
                            issued <= {{(LEN_W-1){1'b0}}, 1'b1};
                        end else begin
                            // Empty dot product: answer immediately, MAC untouched
                            res_data_q  <= '0;
                            res_valid_q <= 1'b1;
                            state       <= RESULT;
                        end
                    end
                end
                ISSUE: begin
                    if (issued == len) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        a_addr <= a_addr + 1'b1;
                        b_addr <= b_addr + b_stride;
                        issued <= issued + 1'b1;
                    end
                end
                DRAIN: state <= CAPTURE;
                CAPTURE: begin
                    res_data_q  <= bus.mac_acc;
                    res_valid_q <= 1'b1;
                    state       <= RESULT;
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb/tb_mac_operand_sequencer.sv - bench for mac_operand_sequencer with memory and MAC models
module tb_mac_operand_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.ADDR_W(8), .LEN_W(8)) bus ();

    mac_operand_sequencer #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;

    // Operand memories (synchronous read) and the MAC unit
    logic [7:0] amem [256];
    logic [7:0] bmem [256];
    logic signed [15:0] prod;
    logic [31:0] acc = '0;

    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= amem[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= bmem[bus.b_rd_addr];
    end

    assign prod = $signed(bus.mac_a) * $signed(bus.mac_b);
    always @(posedge clk)
        if (bus.mac_enable)
            acc <= bus.mac_start ? {{16{prod[15]}}, prod} : acc + {{16{prod[15]}}, prod};
    assign bus.mac_acc = acc;

    // Event recorder, sampled on the falling edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cyc[$], ra[$], rb[$], en_cyc[$], ma[$], mb[$], st_cyc[$];
    int busy_ready = 0;
    int rden_mismatch = 0;
    bit busy = 1'b0;

    always @(negedge clk) begin
        if (bus.a_rd_en) begin
            rd_cyc.push_back(cyc);
            ra.push_back(int'(bus.a_rd_addr));
            rb.push_back(int'(bus.b_rd_addr));
        end
        if (bus.a_rd_en !== bus.b_rd_en) rden_mismatch++;
        if (bus.mac_enable) begin
            en_cyc.push_back(cyc);
            ma.push_back(int'(bus.mac_a));
            mb.push_back(int'(bus.mac_b));
        end
        if (bus.mac_start) st_cyc.push_back(cyc);
        if (busy && bus.cmd_ready) busy_ready++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int a_addr_of(input int ab, input int i);
        return (ab + i) % 256;
    endfunction

    function automatic int b_addr_of(input int bb, input int st, input int i);
        return (bb + i * st) % 256;
    endfunction

    function automatic int dot(input int ab, input int bb, input int st, input int ln);
        int s = 0;
        for (int i = 0; i < ln; i++) begin
            int av = byte'(amem[a_addr_of(ab, i)]);
            int bv = byte'(bmem[b_addr_of(bb, st, i)]);
            s += av * bv;
        end
        return s;
    endfunction

    task automatic issue_cmd(input int ab, input int bb, input int st, input int ln, output int t);
        int n = 0;
        bus.cmd_valid    = 1'b1;
        bus.cmd_a_base   = 8'(ab);
        bus.cmd_b_base   = 8'(bb);
        bus.cmd_b_stride = 8'(st);
        bus.cmd_len      = 8'(ln);
        while (!bus.cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1'b1);
        t = cyc;
        step();
        bus.cmd_valid = 1'b0;
        rd_cyc.delete(); ra.delete(); rb.delete();
        en_cyc.delete(); ma.delete(); mb.delete(); st_cyc.delete();
        busy_ready = 0;
        busy = 1'b1;
    endtask

    task automatic complete_cmd(input int t, input int ab, input int bb, input int st,
                                input int ln, input int hold);
        int n = 0;
        int exp_sum;
        logic [31:0] held;
        // len==0 may already be in RESULT when issue_cmd returns
        while (!bus.res_valid && n < 400) begin
            step();
            n++;
        end
        check("res_valid_seen", bus.res_valid, 1'b1);
        check("res_valid_cycle", cyc, (ln == 0) ? t + 1 : t + ln + 3);
        exp_sum = dot(ab, bb, st, ln);
        check("res_data", bus.res_data, exp_sum);
        held = bus.res_data;
        for (int h = 0; h < hold; h++) begin
            step();
            check($sformatf("hold_valid[%0d]", h), bus.res_valid, 1'b1);
            check($sformatf("hold_data[%0d]", h), bus.res_data, held);
            check($sformatf("hold_cmd_ready[%0d]", h), bus.cmd_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        busy = 1'b0;
        check("post_hs_valid", bus.res_valid, 1'b0);
        check("post_hs_cmd_ready", bus.cmd_ready, 1'b1);

        check("n_reads", rd_cyc.size(), ln);
        for (int i = 0; i < ln && i < rd_cyc.size(); i++) begin
            check($sformatf("rd_cycle[%0d]", i), rd_cyc[i], t + 1 + i);
            check($sformatf("a_rd_addr[%0d]", i), ra[i], a_addr_of(ab, i));
            check($sformatf("b_rd_addr[%0d]", i), rb[i], b_addr_of(bb, st, i));
        end
        check("n_mac_enable", en_cyc.size(), ln);
        for (int i = 0; i < ln && i < en_cyc.size(); i++) begin
            check($sformatf("mac_en_cycle[%0d]", i), en_cyc[i], t + 2 + i);
            check($sformatf("mac_a[%0d]", i), ma[i], int'(amem[a_addr_of(ab, i)]));
            check($sformatf("mac_b[%0d]", i), mb[i], int'(bmem[b_addr_of(bb, st, i)]));
        end
        check("n_mac_start", st_cyc.size(), (ln != 0) ? 1 : 0);
        if (st_cyc.size() > 0) check("mac_start_cycle", st_cyc[0], t + 2);
        check("cmd_ready_while_busy", busy_ready, 0);
        check("rd_en_pair", rden_mismatch, 0);
    endtask

    task automatic run(input int ab, input int bb, input int st, input int ln, input int hold);
        int t;
        issue_cmd(ab, bb, st, ln, t);
        complete_cmd(t, ab, bb, st, ln, hold);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({pfx, "_a_rd_en"}, bus.a_rd_en, 1'b0);
        check({pfx, "_b_rd_en"}, bus.b_rd_en, 1'b0);
        check({pfx, "_mac_enable"}, bus.mac_enable, 1'b0);
        check({pfx, "_mac_start"}, bus.mac_start, 1'b0);
        check({pfx, "_mac_a"}, bus.mac_a, 8'd0);
        check({pfx, "_mac_b"}, bus.mac_b, 8'd0);
        check({pfx, "_res_valid"}, bus.res_valid, 1'b0);
        check({pfx, "_res_data"}, bus.res_data, 32'd0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a_base = '0;
        bus.cmd_b_base = '0;
        bus.cmd_b_stride = '0;
        bus.cmd_len = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            amem[i] = 8'($urandom);
            bmem[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            amem[i] = 8'(i + 1);
            bmem[i] = 8'(i + 5);
        end
        amem[8'h10] = 8'h80; amem[8'h11] = 8'h80;
        bmem[8'h20] = 8'h80; bmem[8'h21] = 8'h7F;
        amem[8'h50] = 8'h01; bmem[8'h60] = 8'h01;

        repeat (3) step();
        check_idle_outputs("reset");
        reset = 1'b0;
        step();

        // Basic 1..4 . 5..8 = 70 under 5 cycles of backpressure
        run(0, 0, 1, 4, 5);
        check("dot_70_model", dot(0, 0, 1, 4), 70);
        // Signed extremes: 16384 - 16256
        run(8'h10, 8'h20, 0, 0, 0);
        run(8'h10, 8'h20, 1, 2, 0);
        // Column walk wrapping past 0xFF
        run(8'h40, 8'hFE, 3, 3, 1);
        // Back-to-back: 70 then 1*1 must not inherit the old accumulator
        run(0, 0, 1, 4, 0);
        run(8'h50, 8'h60, 1, 1, 0);
        // Empty command
        run(8'h33, 8'h44, 7, 0, 2);

        // Reset after two of four reads, then a clean rerun
        issue_cmd(0, 0, 1, 4, t);
        step();
        reset = 1'b1;
        step();
        busy = 1'b0;
        check_idle_outputs("midreset");
        reset = 1'b0;
        step();
        run(0, 0, 1, 4, 0);

        // Longest command
        run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 255, 0);

        for (int k = 0; k < 12; k++)
            run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
